// File: rtl/trigger_chain_cfg_sequencer.sv
// Replays a preloaded (address, data) table as single Wishbone writes into the
// trigger-chain configuration space, reporting completion or the first fault.
module trigger_chain_cfg_sequencer #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                wb_clk_i,
    input  logic                wb_aresetn,
    input  logic                tbl_we_i,
    input  logic [IDX_W-1:0]    tbl_idx_i,
    input  logic [ADDR_W-1:0]   tbl_adr_i,
    input  logic [DATA_W-1:0]   tbl_dat_i,
    input  logic                start_i,
    input  logic [IDX_W:0]      count_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [1:0]          err_code_o,
    output logic [IDX_W-1:0]    err_idx_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_REQ} state_e;

    localparam logic [1:0] CODE_BUS   = 2'd1;
    localparam logic [1:0] CODE_ABORT = 2'd2;
    localparam logic [1:0] CODE_TMO   = 2'd3;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [15:0]        wait_q, wait_d;
    logic               cyc_q, cyc_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic [IDX_W-1:0]   eidx_q, eidx_d;
    logic [ADDR_W-1:0]  rd_adr_q;
    logic [DATA_W-1:0]  rd_dat_q;
    logic [IDX_W:0]     cnt_clamp;
    logic               fault;
    logic [1:0]         fault_code;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];

    // Table is write-protected whenever a replay is in flight.
    always_ff @(posedge wb_clk_i) begin
        if (tbl_we_i && state_q == S_IDLE) mem[tbl_idx_i] <= {tbl_adr_i, tbl_dat_i};
    end

    // RAM output register doubles as the bus address/data holding register.
    always_ff @(posedge wb_clk_i or negedge wb_aresetn) begin
        if (!wb_aresetn) begin
            rd_adr_q <= '0;
            rd_dat_q <= '0;
        end else if (state_q == S_FETCH) begin
            {rd_adr_q, rd_dat_q} <= mem[idx_q];
        end
    end

    assign cnt_clamp = (count_i > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : count_i;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        wait_d     = wait_q;
        cyc_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        code_d     = code_q;
        eidx_d     = eidx_q;
        fault      = 1'b0;
        fault_code = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d  = 1'b0;
                    code_d = 2'd0;
                    eidx_d = '0;
                    if (cnt_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        last_d  = IDX_W'(cnt_clamp - 1'b1);
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (abort_i) begin
                    fault      = 1'b1;
                    fault_code = CODE_ABORT;
                end else begin
                    state_d = S_REQ;
                    cyc_d   = 1'b1;
                    wait_d  = '0;
                end
            end
            S_REQ: begin
                // Abort beats err beats ack; timeout only if nothing terminated.
                if (abort_i) begin
                    fault      = 1'b1;
                    fault_code = CODE_ABORT;
                end else if (wbm_err_i) begin
                    fault      = 1'b1;
                    fault_code = CODE_BUS;
                end else if (wbm_ack_i) begin
                    if (idx_q == last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    fault      = 1'b1;
                    fault_code = CODE_TMO;
                end else begin
                    wait_d = wait_q + 16'd1;
                    cyc_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fault) begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            code_d  = fault_code;
            eidx_d  = idx_q;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_aresetn) begin
        if (!wb_aresetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            wait_q  <= '0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            eidx_q  <= eidx_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign err_idx_o  = eidx_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = cyc_q;
    assign wbm_sel_o  = {(DATA_W/8){cyc_q}};
    assign wbm_adr_o  = rd_adr_q;
    assign wbm_dat_o  = rd_dat_q;

endmodule

// File: tb/tb_trigger_chain_cfg_sequencer.sv
// Directed bench: a Wishbone slave model retires writes against a scoreboard of
// expected (address, data) pairs; the main sequence checks timing and faults.
module tb_trigger_chain_cfg_sequencer;

    localparam int DEPTH  = 64;
    localparam int IDX_W  = 6;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tbl_we_i = 1'b0;
    logic [IDX_W-1:0]  tbl_idx_i = '0;
    logic [ADDR_W-1:0] tbl_adr_i = '0;
    logic [DATA_W-1:0] tbl_dat_i = '0;
    logic              start_i = 1'b0;
    logic [IDX_W:0]    count_i = '0;
    logic              abort_i = 1'b0;
    logic              busy_o, done_o, err_o;
    logic [1:0]        err_code_o;
    logic [IDX_W-1:0]  err_idx_o;
    logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic [3:0]        wbm_sel_o;
    logic              wbm_ack_i = 1'b0;
    logic              wbm_err_i = 1'b0;

    int errors = 0;
    int checks = 0;

    // Slave model configuration and state
    bit  noack = 0;
    int  err_ent = -1, dly_ent = -1, dly = 0, abort_ent = -1;
    int  ent = 0, wcnt = 0, stb_cnt = 0;
    bit  abort_chk = 0;
    logic [ADDR_W-1:0] cap_adr;
    logic [DATA_W-1:0] cap_dat;
    logic [ADDR_W+DATA_W-1:0] sb [$];

    trigger_chain_cfg_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_aresetn(rst_n),
        .tbl_we_i(tbl_we_i), .tbl_idx_i(tbl_idx_i), .tbl_adr_i(tbl_adr_i), .tbl_dat_i(tbl_dat_i),
        .start_i(start_i), .count_i(count_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .err_idx_o(err_idx_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: drives terminations on the falling edge, retires writes into the scoreboard.
    initial forever begin
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        abort_i   = 1'b0;
        if (abort_chk) begin
            chk("cyc_after_abort", wbm_cyc_o, 0);
            abort_chk = 0;
        end
        if (wbm_cyc_o && wbm_stb_o) begin
            stb_cnt++;
            if (wcnt == 0) begin
                cap_adr = wbm_adr_o;
                cap_dat = wbm_dat_o;
                chk("we_sel", {wbm_we_o, wbm_sel_o}, 5'h1f);
            end else begin
                chk("adr_stable", wbm_adr_o, cap_adr);
                chk("dat_stable", wbm_dat_o, cap_dat);
            end
            wcnt++;
            if (!noack) begin
                if (ent == err_ent) begin
                    wbm_err_i = 1'b1;
                    wcnt = 0;
                end else if (wcnt > ((ent == dly_ent) ? dly + 1 : 1) - 1) begin
                    wbm_ack_i = 1'b1;
                    if (ent == abort_ent) begin
                        abort_i   = 1'b1;
                        abort_chk = 1;
                    end else begin
                        chk("sb_nonempty", sb.size() != 0, 1);
                        if (sb.size() != 0) chk("write", {cap_adr, cap_dat}, sb.pop_front());
                    end
                    ent++;
                    wcnt = 0;
                end
            end
        end
    end

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tbl_we_i  = 1'b1;
            tbl_idx_i = IDX_W'(i);
            tbl_adr_i = ADDR_W'(32'h10 + i);
            tbl_dat_i = DATA_W'(32'hA0 + i);
        end
        @(negedge clk);
        tbl_we_i = 1'b0;
    endtask

    task automatic expect_writes(input int n);
        for (int i = 0; i < n; i++) sb.push_back({ADDR_W'(32'h10 + i), DATA_W'(32'hA0 + i)});
    endtask

    task automatic prep(input bit na, input int ee, input int de, input int d, input int ae);
        noack = na; err_ent = ee; dly_ent = de; dly = d; abort_ent = ae;
        ent = 0; wcnt = 0; stb_cnt = 0; sb.delete();
    endtask

    // Start, then watch busy/done at falling edges until the done pulse has ended.
    task automatic run(input int cnt, input bit inject, output int nb, output int nd);
        bit fin = 0;
        nb = 0; nd = 0;
        @(negedge clk);
        start_i = 1'b1;
        count_i = (IDX_W+1)'(cnt);
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (inject && k == 3) begin
                start_i = 1'b1; count_i = 1;
                tbl_we_i = 1'b1; tbl_idx_i = 3; tbl_adr_i = 'h3ff; tbl_dat_i = 'hdead;
            end else begin
                start_i = 1'b0; tbl_we_i = 1'b0;
            end
            if (busy_o) nb++;
            if (done_o) nd++;
            if (nd > 0 && !done_o) begin
                fin = 1;
                break;
            end
            @(negedge clk);
        end
        chk("run_completed", fin, 1);
    endtask

    int nb, nd;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cyc_stb_we", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("rst_busy_done", {busy_o, done_o}, 0);
        chk("rst_err", {err_o, err_code_o, err_idx_o}, 0);
        chk("rst_adr_dat_sel", {wbm_adr_o, wbm_dat_o, wbm_sel_o}, 0);
        rst_n = 1'b1;
        load(4);

        // Zero-wait replay
        prep(0, -1, -1, 0, -1);
        expect_writes(4);
        run(4, 0, nb, nd);
        chk("a_busy", nb, 8);
        chk("a_done", nd, 1);
        chk("a_err", err_o, 0);
        chk("a_sb_empty", sb.size(), 0);

        // Three wait states on entry 1
        prep(0, -1, 1, 3, -1);
        expect_writes(4);
        run(4, 0, nb, nd);
        chk("b_busy", nb, 11);
        chk("b_done", nd, 1);
        chk("b_err", err_o, 0);
        chk("b_sb_empty", sb.size(), 0);

        // Bus error on entry 2
        prep(0, 2, -1, 0, -1);
        expect_writes(2);
        run(4, 0, nb, nd);
        chk("c_stb", stb_cnt, 3);
        chk("c_err", {err_o, err_code_o}, 3'b101);
        chk("c_idx", err_idx_o, 2);
        chk("c_done", nd, 1);
        chk("c_sb_empty", sb.size(), 0);
        prep(0, -1, -1, 0, -1);
        expect_writes(1);
        run(1, 0, nb, nd);
        chk("c_clear", {err_o, err_code_o}, 0);
        chk("c_clear_done", nd, 1);

        // Timeout with no ack
        prep(1, -1, -1, 0, -1);
        run(4, 0, nb, nd);
        chk("d_stb", stb_cnt, 16);
        chk("d_err", {err_o, err_code_o}, 3'b111);
        chk("d_idx", err_idx_o, 0);
        chk("d_done", nd, 1);

        // Abort coincident with ack on entry 1
        prep(0, -1, -1, 0, 1);
        expect_writes(1);
        run(4, 0, nb, nd);
        chk("e_err", {err_o, err_code_o}, 3'b110);
        chk("e_idx", err_idx_o, 1);
        chk("e_done", nd, 1);
        chk("e_sb_empty", sb.size(), 0);

        // count = 0
        prep(0, -1, -1, 0, -1);
        run(0, 0, nb, nd);
        chk("f_done", nd, 1);
        chk("f_busy", nb, 0);
        chk("f_stb", stb_cnt, 0);
        chk("f_err_clear", err_o, 0);

        // start and table write while busy are dropped
        prep(0, -1, -1, 0, -1);
        expect_writes(4);
        run(4, 1, nb, nd);
        chk("g_busy", nb, 8);
        chk("g_done", nd, 1);
        prep(0, -1, -1, 0, -1);
        expect_writes(4);
        run(4, 0, nb, nd);
        chk("g_sb_empty", sb.size(), 0);

        // Reset mid-REQ
        prep(1, -1, -1, 0, -1);
        @(negedge clk);
        start_i = 1'b1; count_i = 4;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("h_cyc_before", wbm_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("h_cyc_stb", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("h_status", {busy_o, done_o, err_o, err_code_o, err_idx_o}, 0);
        chk("h_bus", {wbm_adr_o, wbm_dat_o, wbm_sel_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prep(0, -1, -1, 0, -1);
        expect_writes(4);
        run(4, 0, nb, nd);
        chk("h_replay_busy", nb, 8);
        chk("h_replay_sb", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
